// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and types for the slave return-path mux.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int NUM_PORTS = 5;

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_ERR1 = 2'b01,
        D_ERR2 = 2'b10
    } dflt_state_e;

    // Keep only the lowest set bit, so the lowest-numbered port wins.
    function automatic logic [NUM_PORTS-1:0] lowest_one(input logic [NUM_PORTS-1:0] v);
        return v & (~v + NUM_PORTS'(1));
    endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Built-in default slave: two-cycle ERROR response for unmapped active
// transfers, plus a saturating count of those responses.
//
// state  | meaning
// D_IDLE | no error in progress, drives OKAY / ready
// D_ERR1 | first error cycle: HREADYOUT=0, HRESP=ERROR, count bumps
// D_ERR2 | second error cycle: HREADYOUT=1, HRESP=ERROR, next address sampled
module ahblite_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    input  logic       no_sel_i,
    output logic       dflt_hreadyout_o,
    output logic       dflt_hresp_o,
    output logic [7:0] err_cnt_o
);

    dflt_state_e state_q, state_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        active;
    logic        arm;

    assign active    = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign arm       = HREADY & no_sel_i & active;
    assign err_cnt_o = err_cnt_q;

    // State and counter registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= D_IDLE;
            err_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Next state, counter update and default-slave response.
    always_comb begin
        state_d          = state_q;
        err_cnt_d        = err_cnt_q;
        dflt_hreadyout_o = 1'b1;
        dflt_hresp_o     = HRESP_OKAY;
        case (state_q)
            D_IDLE: begin
                if (arm) state_d = D_ERR1;
            end
            D_ERR1: begin
                dflt_hreadyout_o = 1'b0;
                dflt_hresp_o     = HRESP_ERROR;
                state_d          = D_ERR2;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
            D_ERR2: begin
                dflt_hresp_o = HRESP_ERROR;
                state_d      = arm ? D_ERR1 : D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase
    end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite slave return-path mux: registers the decoder select during the
// address phase and routes the selected slave's response in the data phase.
// Unmapped or disabled-port transfers are answered by the default slave.
module ahblite_slave_mux
    import ahb_pkg::*;
#(
    parameter logic Port0_en = 1'b1,
    parameter logic Port1_en = 1'b1,
    parameter logic Port2_en = 1'b1,
    parameter logic Port3_en = 1'b1,
    parameter logic Port4_en = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P4_HSEL,
    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P4_HREADYOUT,
    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic        P4_HRESP,
    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    input  logic [31:0] P4_HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [7:0]  ERR_CNT
);

    localparam logic [NUM_PORTS-1:0] EN_MASK = {Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};

    logic [NUM_PORTS-1:0] hsel_vec;
    logic [NUM_PORTS-1:0] eff_sel;
    logic [NUM_PORTS-1:0] sel_q, sel_d;
    logic [NUM_PORTS-1:0] rdy_vec;
    logic [NUM_PORTS-1:0] resp_vec;
    logic [31:0]          rdata_arr [NUM_PORTS];
    logic                 no_sel;
    logic                 dflt_hreadyout;
    logic                 dflt_hresp;

    assign hsel_vec  = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL};
    assign rdy_vec   = {P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
    assign resp_vec  = {P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
    assign rdata_arr[0] = P0_HRDATA;
    assign rdata_arr[1] = P1_HRDATA;
    assign rdata_arr[2] = P2_HRDATA;
    assign rdata_arr[3] = P3_HRDATA;
    assign rdata_arr[4] = P4_HRDATA;

    // A disabled port looks exactly like an unmapped address.
    assign eff_sel = lowest_one(hsel_vec & EN_MASK);
    assign no_sel  = (eff_sel == '0);

    // Capture the select only when the bus is ready; wait states hold it.
    always_comb begin
        sel_d = HREADY ? eff_sel : sel_q;
    end

    // Data-phase select register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) sel_q <= '0;
        else          sel_q <= sel_d;
    end

    ahblite_default_slave u_dflt (
        .HCLK             (HCLK),
        .HRESETn          (HRESETn),
        .HREADY           (HREADY),
        .HTRANS           (HTRANS),
        .no_sel_i         (no_sel),
        .dflt_hreadyout_o (dflt_hreadyout),
        .dflt_hresp_o     (dflt_hresp),
        .err_cnt_o        (ERR_CNT)
    );

    // Return-path mux; the default slave answers whenever no port is selected.
    always_comb begin
        HREADYOUT = dflt_hreadyout;
        HRESP     = dflt_hresp;
        HRDATA    = 32'h0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_q[i]) begin
                HREADYOUT = rdy_vec[i];
                HRESP     = resp_vec[i];
                HRDATA    = rdata_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
module tb_ahblite_slave_mux;

    logic        clk;
    logic        rst_n;
    logic [1:0]  htrans;
    logic [4:0]  hsel;
    logic [4:0]  p_rdy;
    logic [4:0]  p_resp;
    logic [31:0] p_data [5];

    // index 0: all ports enabled, index 1: port 3 disabled
    logic [1:0]  rdy;
    logic [1:0]  resp;
    logic [31:0] data [2];
    logic [7:0]  cnt [2];

    int total = 0;
    int bad   = 0;

    // reference model state: data-phase owner, error phase, error count
    int m_port [2];
    int m_err  [2];
    int m_cnt  [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ahblite_slave_mux dut_a (
        .HCLK(clk), .HRESETn(rst_n), .HREADY(rdy[0]), .HTRANS(htrans),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
        .P0_HREADYOUT(p_rdy[0]), .P1_HREADYOUT(p_rdy[1]), .P2_HREADYOUT(p_rdy[2]),
        .P3_HREADYOUT(p_rdy[3]), .P4_HREADYOUT(p_rdy[4]),
        .P0_HRESP(p_resp[0]), .P1_HRESP(p_resp[1]), .P2_HRESP(p_resp[2]),
        .P3_HRESP(p_resp[3]), .P4_HRESP(p_resp[4]),
        .P0_HRDATA(p_data[0]), .P1_HRDATA(p_data[1]), .P2_HRDATA(p_data[2]),
        .P3_HRDATA(p_data[3]), .P4_HRDATA(p_data[4]),
        .HREADYOUT(rdy[0]), .HRESP(resp[0]), .HRDATA(data[0]), .ERR_CNT(cnt[0])
    );

    ahblite_slave_mux #(.Port3_en(1'b0)) dut_b (
        .HCLK(clk), .HRESETn(rst_n), .HREADY(rdy[1]), .HTRANS(htrans),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
        .P0_HREADYOUT(p_rdy[0]), .P1_HREADYOUT(p_rdy[1]), .P2_HREADYOUT(p_rdy[2]),
        .P3_HREADYOUT(p_rdy[3]), .P4_HREADYOUT(p_rdy[4]),
        .P0_HRESP(p_resp[0]), .P1_HRESP(p_resp[1]), .P2_HRESP(p_resp[2]),
        .P3_HRESP(p_resp[3]), .P4_HRESP(p_resp[4]),
        .P0_HRDATA(p_data[0]), .P1_HRDATA(p_data[1]), .P2_HRDATA(p_data[2]),
        .P3_HRDATA(p_data[3]), .P4_HRDATA(p_data[4]),
        .HREADYOUT(rdy[1]), .HRESP(resp[1]), .HRDATA(data[1]), .ERR_CNT(cnt[1])
    );

    function automatic logic [4:0] en_mask(int k);
        return (k == 0) ? 5'b11111 : 5'b10111;
    endfunction

    // expected {HREADYOUT, HRESP, HRDATA} from the model's view of the data phase
    function automatic logic [33:0] exp_out(int k);
        if (m_port[k] >= 0) return {p_rdy[m_port[k]], p_resp[m_port[k]], p_data[m_port[k]]};
        if (m_err[k] == 1)  return {1'b0, 1'b1, 32'h0};
        if (m_err[k] == 2)  return {1'b1, 1'b1, 32'h0};
        return {1'b1, 1'b0, 32'h0};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_port[k] = -1;
            m_err[k]  = 0;
            m_cnt[k]  = 0;
        end
    endtask

    // advance one clock, updating the model on the edge with the transfer rules
    task automatic tick();
        logic [1:0]  r;
        logic [33:0] e;
        logic [4:0]  m;
        int          p;
        for (int k = 0; k < 2; k++) begin
            e    = exp_out(k);
            r[k] = e[33];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (m_err[k] == 1) begin
                m_err[k] = 2;
                if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
            end else if (r[k]) begin
                m = hsel & en_mask(k);
                p = -1;
                for (int i = 4; i >= 0; i--) if (m[i]) p = i;
                m_port[k] = p;
                m_err[k]  = (p < 0 && htrans[1]) ? 1 : 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        htrans = 2'b00;
        hsel   = 5'b0;
        p_rdy  = 5'b11111;
        p_resp = 5'b0;
        for (int i = 0; i < 5; i++) p_data[i] = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({rdy[k], resp[k], data[k]} !== {1'b1, 1'b0, 32'h0}) begin
                bad++;
                $display("FAIL reset_out[%0d] got=%h want=%h", k, {rdy[k], resp[k], data[k]}, {1'b1, 1'b0, 32'h0});
            end
            total++;
            if (cnt[k] !== 8'h00) begin
                bad++;
                $display("FAIL reset_cnt[%0d] got=%h want=00", k, cnt[k]);
            end
        end
    endtask

    task automatic test_p0_read();
        htrans    = 2'b10;
        hsel      = 5'b00001;
        p_data[0] = 32'h1234_5678;
        tick();
        htrans = 2'b00;
        hsel   = 5'b0;
        #1;
        total++;
        if ({rdy[0], resp[0], data[0]} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            bad++;
            $display("FAIL p0_read got=%h want=%h", {rdy[0], resp[0], data[0]}, {1'b1, 1'b0, 32'h1234_5678});
        end
        tick();
    endtask

    task automatic test_wait_states();
        htrans    = 2'b10;
        hsel      = 5'b00010;
        p_data[1] = 32'hAAAA_0001;
        p_data[2] = 32'hBBBB_0002;
        tick();
        p_rdy[1] = 1'b0;
        hsel     = 5'b00100;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({rdy[0], data[0]} !== {1'b0, 32'hAAAA_0001}) begin
                bad++;
                $display("FAIL wait_stall%0d got=%h want=%h", c, {rdy[0], data[0]}, {1'b0, 32'hAAAA_0001});
            end
            tick();
        end
        p_rdy[1] = 1'b1;
        hsel     = 5'b0;
        htrans   = 2'b00;
        #1;
        total++;
        if ({rdy[0], data[0]} !== {1'b1, 32'hAAAA_0001}) begin
            bad++;
            $display("FAIL wait_release got=%h want=%h", {rdy[0], data[0]}, {1'b1, 32'hAAAA_0001});
        end
        tick();
        #1;
        total++;
        if ({rdy[0], resp[0], data[0]} !== {1'b1, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL wait_p2_ignored got=%h want=%h", {rdy[0], resp[0], data[0]}, {1'b1, 1'b0, 32'h0});
        end
    endtask

    task automatic test_back_to_back();
        p_data[2] = 32'h0000_0003;
        p_data[0] = 32'hCAFE_F00D;
        htrans    = 2'b10;
        hsel      = 5'b00100;
        tick();
        hsel = 5'b00001;
        #1;
        total++;
        if ({rdy[0], data[0]} !== {1'b1, 32'h0000_0003}) begin
            bad++;
            $display("FAIL b2b_p2 got=%h want=%h", {rdy[0], data[0]}, {1'b1, 32'h0000_0003});
        end
        tick();
        htrans = 2'b00;
        hsel   = 5'b0;
        #1;
        total++;
        if ({rdy[0], data[0]} !== {1'b1, 32'hCAFE_F00D}) begin
            bad++;
            $display("FAIL b2b_p0 got=%h want=%h", {rdy[0], data[0]}, {1'b1, 32'hCAFE_F00D});
        end
        tick();
    endtask

    task automatic test_unmapped();
        htrans = 2'b10;
        hsel   = 5'b0;
        tick();
        htrans = 2'b00;
        #1;
        total++;
        if ({rdy[0], resp[0], data[0]} !== {1'b0, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL unmapped_err1 got=%h want=%h", {rdy[0], resp[0], data[0]}, {1'b0, 1'b1, 32'h0});
        end
        tick();
        #1;
        total++;
        if ({rdy[0], resp[0]} !== 2'b11) begin
            bad++;
            $display("FAIL unmapped_err2 got=%b want=11", {rdy[0], resp[0]});
        end
        total++;
        if (cnt[0] !== 8'd1) begin
            bad++;
            $display("FAIL unmapped_cnt got=%0d want=1", cnt[0]);
        end
        tick();
        #1;
        total++;
        if ({rdy[0], resp[0]} !== 2'b10) begin
            bad++;
            $display("FAIL unmapped_back_idle got=%b want=10", {rdy[0], resp[0]});
        end
    endtask

    task automatic test_saturation();
        htrans = 2'b10;
        hsel   = 5'b0;
        repeat (2 * 260) tick();
        htrans = 2'b00;
        repeat (3) tick();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (cnt[k] !== 8'hFF) begin
                bad++;
                $display("FAIL saturate_cnt[%0d] got=%h want=ff", k, cnt[k]);
            end
        end
    endtask

    task automatic test_port3_disabled();
        idle_inputs();
        do_reset();
        p_data[3] = 32'h3333_3333;
        htrans    = 2'b10;
        hsel      = 5'b01000;
        tick();
        htrans = 2'b00;
        #1;
        total++;
        if ({rdy[1], resp[1], data[1]} !== {1'b0, 1'b1, 32'h0}) begin
            bad++;
            $display("FAIL p3dis_err1 got=%h want=%h", {rdy[1], resp[1], data[1]}, {1'b0, 1'b1, 32'h0});
        end
        total++;
        if (data[0] !== 32'h3333_3333) begin
            bad++;
            $display("FAIL p3en_data got=%h want=33333333", data[0]);
        end
        tick();
        #1;
        total++;
        if ({rdy[1], resp[1], cnt[1]} !== {1'b1, 1'b1, 8'd1}) begin
            bad++;
            $display("FAIL p3dis_err2 got=%h want=%h", {rdy[1], resp[1], cnt[1]}, {1'b1, 1'b1, 8'd1});
        end
        tick();
        #1;
        total++;
        if ({rdy[1], resp[1], data[1], cnt[1]} !== {1'b1, 1'b0, 32'h0, 8'd1}) begin
            bad++;
            $display("FAIL p3dis_idle got=%h want=%h", {rdy[1], resp[1], data[1], cnt[1]}, {1'b1, 1'b0, 32'h0, 8'd1});
        end
        tick();
    endtask

    task automatic test_reset_mid_error();
        htrans = 2'b10;
        hsel   = 5'b0;
        tick();
        htrans = 2'b00;
        #1;
        total++;
        if (rdy[0] !== 1'b0) begin
            bad++;
            $display("FAIL midrst_in_err1 got=%b want=0", rdy[0]);
        end
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({rdy[k], resp[k], data[k], cnt[k]} !== {1'b1, 1'b0, 32'h0, 8'h0}) begin
                bad++;
                $display("FAIL midrst_out[%0d] got=%h want=%h", k, {rdy[k], resp[k], data[k], cnt[k]},
                         {1'b1, 1'b0, 32'h0, 8'h0});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [33:0] e;
        for (int n = 0; n < 600; n++) begin
            htrans = 2'($urandom_range(0, 3));
            for (int i = 0; i < 5; i++) begin
                hsel[i]   = ($urandom_range(0, 9) < 3);
                p_rdy[i]  = ($urandom_range(0, 9) < 8);
                p_resp[i] = ($urandom_range(0, 9) == 0);
                p_data[i] = $urandom;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                e = exp_out(k);
                total++;
                if ({rdy[k], resp[k], data[k]} !== e || cnt[k] !== 8'(m_cnt[k])) begin
                    bad++;
                    $display("FAIL rand[%0d] cyc=%0d got=%h/%h want=%h/%h", k, n,
                             {rdy[k], resp[k], data[k]}, cnt[k], e, 8'(m_cnt[k]));
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_p0_read();
        test_wait_states();
        test_back_to_back();
        test_unmapped();
        test_saturation();
        test_port3_disabled();
        test_reset_mid_error();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
